// File: rtl/score_keeper.sv
// score_keeper
//   Running four-digit BCD game score plus session high score, and the
//   IDLE -> PLAY -> OVER game sequencer. On a crash the larger of score and
//   high score is kept in the high-score register. A record flag marks a
//   game that ended with a strictly higher score.
//
//   Optional feature macro: SCORE_KEEPER_BLINK_EN
//     defined   : new_record blinks with a half-period of BLINK_CYCLES clocks
//                 while in OVER after a record.
//     undefined : new_record is a steady level; no blink counter exists.
//
// Ports
//   clk                      system clock, rising edge
//   reset                    synchronous active-high reset (clears hi too)
//   start, point, crash      single-cycle game event pulses
//   clr_hi                   single-cycle pulse clearing the high score
//   score0..score3           current score BCD digits (ones .. thousands)
//   hi0..hi3                 high-score BCD digits (ones .. thousands)
//   state                    2'b00 IDLE, 2'b01 PLAY, 2'b10 OVER
//   new_record               game just ended with a strictly higher score
module score_keeper #(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       point,
  input  logic       crash,
  input  logic       clr_hi,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic [3:0] hi0,
  output logic [3:0] hi1,
  output logic [3:0] hi2,
  output logic [3:0] hi3,
  output logic [1:0] state,
  output logic       new_record
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] score_r, score_s;   // packed BCD, thousands in [15:12]
  logic [15:0] hi_r, hi_s;
  logic        record_r, record_s;

  // BCD increment that saturates at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
            carry       = 1'b1;
          end else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4];
        end
      end
    end
    return r;
  endfunction

  // Packed BCD with thousands in the MSBs orders exactly like the decimal
  // value, so a plain unsigned compare is the digit-wise comparison.
  function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
    return a > b;
  endfunction

  if (BLINK_CYCLES < 1) begin : g_bad_blink_cycles
    $error("score_keeper: BLINK_CYCLES must be at least 1");
  end

  // Next-state, score, high-score and record-flag logic.
  always_comb begin
    state_s  = state_r;
    score_s  = score_r;
    hi_s     = hi_r;
    record_s = record_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s  = ST_PLAY;
          score_s  = 16'h0000;
          record_s = 1'b0;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_PLAY: begin
        // crash beats a simultaneous point; compare uses the pre-edge score
        if (crash) begin
          state_s = ST_OVER;
          if (bcd_gt(score_r, hi_r)) begin
            hi_s     = score_r;
            record_s = 1'b1;
          end else begin
            record_s = 1'b0;
          end
        end else if (point) begin
          score_s = bcd_inc(score_r);
        end else begin
          score_s = score_r;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_s  = ST_PLAY;
          score_s  = 16'h0000;
          record_s = 1'b0;
        end else begin
          state_s  = ST_OVER;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        score_s  = 16'h0000;
        record_s = 1'b0;
      end
    endcase
    // clearing the high score overrides any crash update on the same edge
    if (clr_hi) begin
      hi_s     = 16'h0000;
      record_s = 1'b0;
    end else begin
      hi_s     = hi_s;
    end
  end

  // State, score, high-score and record-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      score_r  <= 16'h0000;
      hi_r     <= 16'h0000;
      record_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      score_r  <= score_s;
      hi_r     <= hi_s;
      record_r <= record_s;
    end
  end

`ifdef SCORE_KEEPER_BLINK_EN
  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

  logic [CNT_W-1:0] blink_cnt_r;
  logic             blink_r;

  // Blink generator: restarts high on the edge entering OVER with a record,
  // then toggles every BLINK_CYCLES clocks; forced low otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r <= {CNT_W{1'b0}};
      blink_r     <= 1'b0;
    end else if (record_s && (state_s == ST_OVER) && (state_r != ST_OVER)) begin
      blink_cnt_r <= {CNT_W{1'b0}};
      blink_r     <= 1'b1;
    end else if (record_s && (state_s == ST_OVER)) begin
      if (blink_cnt_r == CNT_LAST) begin
        blink_cnt_r <= {CNT_W{1'b0}};
        blink_r     <= ~blink_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + CNT_W'(1);
        blink_r     <= blink_r;
      end
    end else begin
      blink_cnt_r <= {CNT_W{1'b0}};
      blink_r     <= 1'b0;
    end
  end

  assign new_record = blink_r;
`else
  assign new_record = record_r;
`endif

  assign score0 = score_r[3:0];
  assign score1 = score_r[7:4];
  assign score2 = score_r[11:8];
  assign score3 = score_r[15:12];
  assign hi0    = hi_r[3:0];
  assign hi1    = hi_r[7:4];
  assign hi2    = hi_r[11:8];
  assign hi3    = hi_r[15:12];
  assign state  = state_r;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam int BLINK = 4;

  logic       clk = 1'b0;
  logic       reset, start, point, crash, clr_hi;
  logic [3:0] score0, score1, score2, score3;
  logic [3:0] hi0, hi1, hi2, hi3;
  logic [1:0] state;
  logic       new_record;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // reference model: plain integers
  int m_st  = 0;   // 0 IDLE, 1 PLAY, 2 OVER
  int m_sc  = 0;
  int m_hi  = 0;
  bit m_rec = 1'b0;
  int m_k   = 0;   // clock edges since entering OVER

  score_keeper #(.BLINK_CYCLES(BLINK)) dut (
    .clk(clk), .reset(reset), .start(start), .point(point), .crash(crash),
    .clr_hi(clr_hi),
    .score0(score0), .score1(score1), .score2(score2), .score3(score3),
    .hi0(hi0), .hi1(hi1), .hi2(hi2), .hi3(hi3),
    .state(state), .new_record(new_record)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic exp_nr();
`ifdef SCORE_KEEPER_BLINK_EN
    return m_rec && (m_st == 2) && (((m_k / BLINK) % 2) == 0);
`else
    return m_rec;
`endif
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // model update from the rules, on each rising edge
  always @(posedge clk) begin
    int nst, nsc, nhi;
    bit nrec;
    if (reset) begin
      m_st <= 0; m_sc <= 0; m_hi <= 0; m_rec <= 1'b0; m_k <= 0;
    end else begin
      nst = m_st; nsc = m_sc; nhi = m_hi; nrec = m_rec;
      if (m_st == 0 && start) begin
        nst = 1; nsc = 0; nrec = 1'b0;
      end else if (m_st == 1 && crash) begin
        nst = 2;
        if (m_sc > m_hi) begin nhi = m_sc; nrec = 1'b1; end
        else nrec = 1'b0;
      end else if (m_st == 1 && point) begin
        nsc = (m_sc < 9999) ? m_sc + 1 : 9999;
      end else if (m_st == 2 && start) begin
        nst = 1; nsc = 0; nrec = 1'b0;
      end
      if (clr_hi) begin nhi = 0; nrec = 1'b0; end
      m_k   <= (nst == 2 && m_st != 2) ? 0 : m_k + 1;
      m_st  <= nst; m_sc <= nsc; m_hi <= nhi; m_rec <= nrec;
    end
  end

  // compare DUT against model every cycle, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", {14'd0, state}, 16'(m_st));
      chk("score", {score3, score2, score1, score0}, to_bcd(m_sc));
      chk("hi", {hi3, hi2, hi1, hi0}, to_bcd(m_hi));
      chk("new_record", {15'd0, new_record}, {15'd0, exp_nr()});
    end
  end

  task automatic cyc(input logic r, input logic s, input logic p,
                     input logic c, input logic h);
    reset = r; start = s; point = p; crash = c; clr_hi = h;
    @(negedge clk);
  endtask

  task automatic points(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pin(input string nm, input logic [1:0] st, input logic [15:0] sc,
                     input logic [15:0] h, input logic nr);
    chk({nm, ".state"}, {14'd0, state}, {14'd0, st});
    chk({nm, ".score"}, {score3, score2, score1, score0}, sc);
    chk({nm, ".hi"}, {hi3, hi2, hi1, hi0}, h);
    chk({nm, ".nr"}, {15'd0, new_record}, {15'd0, nr});
  endtask

  initial begin
    logic nr_exp;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    pin("reset", 2'b00, 16'h0000, 16'h0000, 1'b0);
    // point and crash ignored in IDLE
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pin("idle_ign", 2'b00, 16'h0000, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    points(12);
    pin("pts12", 2'b01, 16'h0012, 16'h0000, 1'b0);
    points(87);
    pin("s99", 2'b01, 16'h0099, 16'h0000, 1'b0);
    points(1);
    pin("s100", 2'b01, 16'h0100, 16'h0000, 1'b0);
    points(9899);
    pin("s9999", 2'b01, 16'h9999, 16'h0000, 1'b0);
    points(1);
    pin("sat", 2'b01, 16'h9999, 16'h0000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // start in PLAY ignored
    pin("play_start", 2'b01, 16'h9999, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pin("crash9999", 2'b10, 16'h9999, 16'h9999, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pin("clr", 2'b10, 16'h9999, 16'h0000, 1'b0);
    // first record at 15, then equal score is not a record
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    points(15);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pin("rec15", 2'b10, 16'h0015, 16'h0015, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pin("restart", 2'b01, 16'h0000, 16'h0015, 1'b0);
    points(15);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pin("eq15", 2'b10, 16'h0015, 16'h0015, 1'b0);
    // hi=40, score 39, point+crash together
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    points(40);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    points(39);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    pin("pt_crash", 2'b10, 16'h0039, 16'h0040, 1'b0);
    // hi=20, score 30, crash+clr_hi together
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    points(20);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    points(30);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    pin("crash_clr", 2'b10, 16'h0030, 16'h0000, 1'b0);
    // record crash, then watch new_record level / blink
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    points(5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
`ifdef SCORE_KEEPER_BLINK_EN
      nr_exp = ((i / 4) % 2) == 0;
`else
      nr_exp = 1'b1;
`endif
      chk($sformatf("blink%0d", i), {15'd0, new_record}, {15'd0, nr_exp});
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pin("start_drop", 2'b01, 16'h0000, 16'h0005, 1'b0);
    // reset mid-game clears hi too
    points(3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pin("mid_reset", 2'b00, 16'h0000, 16'h0000, 1'b0);
    // randomized traffic checked by the model
    for (int i = 0; i < 6000; i++) begin
      cyc($urandom_range(0, 999) < 3,
          $urandom_range(0, 99) < 6,
          $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 199) < 2);
    end
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Holds the running four-digit BCD game score and the session high score. Produces the score and high-score digit buses that feed the score comparator and the HEX display drivers. Sequences the game as IDLE → PLAY → OVER. On a crash it registers the larger of score and high score into the high-score register.

## Interface
- BLINK_CYCLES, default 25_000_000: half-period, in clk cycles, of the new-record blink (used only when blinking is compiled in).
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a new game.
- point  input  1  single-cycle pulse: bird cleared a pipe, score +1.
- crash  input  1  single-cycle pulse: bird collided, game ends.
- clr_hi  input  1  single-cycle pulse that clears the high score.
- score0, score1, score2, score3  output  4 each  current score BCD digits (ones, tens, hundreds, thousands).
- hi0, hi1, hi2, hi3  output  4 each  high-score BCD digits (same digit order).
- state  output  2  game state: 2'b00 IDLE, 2'b01 PLAY, 2'b10 OVER; 2'b11 never driven.
- new_record  output  1  set when the game just ended with a strictly higher score.

## Operation
- All outputs are registered.
- Reset: state=IDLE; all score and hi digits = 0; new_record=0; blink counter=0.
- IDLE:
  - start → PLAY, score cleared to 0000.
  - point and crash ignored.
- PLAY:
  - point increments score in BCD. A digit at 9 wraps to 0 and carries into the next digit.
  - Score saturates at 9999: a further point leaves all digits at 9.
  - crash → OVER. On the same edge, if score > hi (digit-wise, thousands first), hi ← score and new_record ← 1. Otherwise hi is unchanged and new_record ← 0.
  - crash and point in the same cycle: crash wins. The point is discarded, and the comparison uses the pre-edge score.
  - start in PLAY is ignored.
- OVER:
  - Score holds its final value.
  - start → PLAY: score cleared to 0000, new_record ← 0.
  - point and crash ignored.
- clr_hi:
  - Valid in any state; all hi digits ← 0 on the next edge.
  - Takes priority over a simultaneous crash update. On that edge new_record ← 0; state and score still follow crash.
- start and crash in the same cycle: crash takes effect if in PLAY, start if in IDLE/OVER. Only one of the two can ever apply.
- Equal score and high score is not a record: hi is unchanged, new_record=0.
- Score and hi digits are always valid BCD (0–9).

## Timing
- Input pulse at edge N → result visible after edge N (one-cycle latency) for score, hi, state and new_record.
- Back-to-back point pulses on consecutive cycles each count. 10 pulses from 0000 give 0010 ten cycles later.
- reset asserted mid-game overrides everything on that edge, including clearing hi.
- No handshakes; inputs are assumed to be pre-synchronised single-cycle pulses.

## Configuration
- SCORE_KEEPER_BLINK_EN defined:
  - While state=OVER and a record was set, new_record toggles every BLINK_CYCLES clk cycles, starting high on the edge entering OVER.
  - The counter resets on that edge.
  - new_record is forced to 0 when leaving OVER, on clr_hi, or on reset.
- Not defined: new_record is a steady level, set on the record edge and held until start, clr_hi or reset. No counter logic is generated.

## Test plan
- Reset, then start, then 12 point pulses → state=01, score digits 3..0 = 0,0,1,2; hi=0000; new_record=0.
- Score 0099, one point → 0100 next cycle. Score 9999, one point → stays 9999.
- Scores 0015 then crash → state=10, hi=0015, new_record=1. Start, 0015 again, crash → hi=0015, new_record=0 (equal is not a record).
- hi=0040, score 0039, point and crash in the same cycle → score stays 0039, hi=0040, new_record=0, state=OVER.
- hi=0020, score 0030, crash and clr_hi in the same cycle → hi=0000, new_record=0, state=OVER, score=0030.
- With SCORE_KEEPER_BLINK_EN and BLINK_CYCLES=4, record crash → new_record is high 4 cycles, low 4, high 4. A start then drops it to 0 on the next edge. Without the macro it stays 1 until start.
